cpu_sequencer: RTL

- Programmable micro-sequencer that drives the 4-bit register/mux/ALU datapath control lines: alu_sel, mux_sel and load.
- Replaces the free-running PC + fixed ROM arrangement with a host-loadable program store, start/busy/done handshake, conditional branch on ALU carry, HALT, abort and a step watchdog.
- Sits between the host/test interface and the datapath. The datapath carry_out feeds back as carry_in.

---
 rtl/cpu_sequencer_if.sv | 59 +++++
 rtl/cpu_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Host/datapath bundle for cpu_sequencer.
//
// The master modport is the host/test side plus the datapath carry feedback.
// The slave modport is the sequencer itself.
//   start, abort                  run control from the host
//   prog_we, prog_addr, prog_wdata program-store write port
//   carry_in                      datapath ALU carry_out, same cycle
//   alu_sel, mux_sel, load        datapath control lines
//   busy, done, fault             run status
//   pc_out                        current program counter, for observation
interface cpu_sequencer_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              start;
    logic              abort;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_wdata;
    logic              carry_in;
    logic [1:0]        alu_sel;
    logic              mux_sel;
    logic              load;
    logic              busy;
    logic              done;
    logic              fault;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output start,
        output abort,
        output prog_we,
        output prog_addr,
        output prog_wdata,
        output carry_in,
        input  alu_sel,
        input  mux_sel,
        input  load,
        input  busy,
        input  done,
        input  fault,
        input  pc_out
    );

    modport slave (
        input  start,
        input  abort,
        input  prog_we,
        input  prog_addr,
        input  prog_wdata,
        input  carry_in,
        output alu_sel,
        output mux_sel,
        output load,
        output busy,
        output done,
        output fault,
        output pc_out
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Programmable micro-sequencer for the 4-bit register/mux/ALU datapath.
//
// A host loads up to 2**ADDR_W instruction words, pulses start, and the
// sequencer executes one instruction per cycle until HALT (-> done), abort
// (-> idle) or the step watchdog expires (-> fault).
//
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset; also clears the program store
//   bus   cpu_sequencer_if.slave: host handshake, program write port,
//         carry feedback, datapath controls, status and pc observation
//
// Instruction word, bits[7:6] = opcode:
//   00 EXEC  bits[3:2] alu_sel, bit[1] mux_sel, bit[0] load
//   01 JMP   bits[ADDR_W-1:0] target
//   10 JC    jump to target when the carry flag is set
//   11 HALT
// MAX_STEPS must lie in 1 .. 2**STEP_W.
module cpu_sequencer #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned MAX_STEPS = 64
) (
    input logic            clk,
    input logic            rstn,
    cpu_sequencer_if.slave bus
);

    localparam int unsigned       Depth     = 2 ** ADDR_W;
    localparam logic [STEP_W-1:0] StepLimit = STEP_W'(MAX_STEPS - 1);

    localparam logic [1:0] OpExec = 2'b00;
    localparam logic [1:0] OpJmp  = 2'b01;
    localparam logic [1:0] OpJc   = 2'b10;
    localparam logic [1:0] OpHalt = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              carry_q, carry_d;
    logic [7:0]        mem_q [Depth];

    logic [7:0]        instr;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              mem_we;
    logic              executing;

    // Bits [5:4] of every word are don't-care.
    logic              unused_instr_bits;

    // Combinational fetch/decode at the current pc.
    assign instr             = mem_q[pc_q];
    assign opcode            = instr[7:6];
    assign target            = instr[ADDR_W-1:0];
    assign pc_inc            = pc_q + ADDR_W'(1);
    assign unused_instr_bits = ^instr[5:4];

    // The store is locked while a program is running.
    assign mem_we = bus.prog_we && (state_q != StRun);

    // An instruction takes effect only in RUN without abort.
    assign executing = (state_q == StRun) && !bus.abort;

    // Datapath controls: only EXEC drives them, and only while executing.
    always_comb begin
        bus.alu_sel = 2'b00;
        bus.mux_sel = 1'b0;
        bus.load    = 1'b0;
        if (executing && (opcode == OpExec)) begin
            bus.alu_sel = instr[3:2];
            bus.mux_sel = instr[1];
            bus.load    = instr[0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        step_d  = step_q;
        carry_d = carry_q;

        unique case (state_q)
            StRun: begin
                // Abort freezes pc, flag and step count; only the state moves.
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    step_d = step_q + STEP_W'(1);
                    unique case (opcode)
                        OpExec: begin
                            pc_d = pc_inc;
                            // Flag tracks carry only when the ALU result is loaded.
                            if (instr[1] && instr[0]) begin
                                carry_d = bus.carry_in;
                            end
                        end
                        OpJmp: begin
                            pc_d = target;
                        end
                        OpJc: begin
                            pc_d = carry_q ? target : pc_inc;
                        end
                        OpHalt: begin
                            state_d = StDone;
                        end
                        default: ;
                    endcase
                    // Watchdog: the final instruction still executes above, but
                    // the run ends here unless it was HALT.
                    if ((opcode != OpHalt) && (step_q == StepLimit)) begin
                        state_d = StFault;
                    end
                end
            end
            StIdle, StDone, StFault: begin
                // A write in the same cycle wins over start.
                if (bus.start && !bus.prog_we) begin
                    state_d = StRun;
                    pc_d    = '0;
                    step_d  = '0;
                    carry_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            pc_q    <= '0;
            step_q  <= '0;
            carry_q <= 1'b0;
            mem_q   <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            carry_q <= carry_d;
            if (mem_we) begin
                mem_q[bus.prog_addr] <= bus.prog_wdata;
            end
        end
    end

    // Status lines decode straight from the state register.
    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.fault  = (state_q == StFault);
    assign bus.pc_out = pc_q;

endmodule
